tcdm_interconnect_wrapper: RTL and testbench

Single-stage, fully combinational-request crossbar connecting `NumMaster` TCDM master ports to `NumBanks = NumMaster*BankFact` word-interleaved SRAM banks. It sits between the cluster cores and the shared L1 banks. It also serves as the common top for simulation and synthesis. Per-bank arbitration grants at most one master per bank per cycle, and read data returns one cycle after grant.

---
 rtl/tcdm_interconnect_wrapper.sv | 145 ++++++++++++++
 tb/tb_tcdm_interconnect_wrapper.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_interconnect_wrapper.sv
// Single-stage TCDM crossbar: NumMaster masters onto NumMaster*BankFact word-interleaved banks.
// Define TCDM_RR_ARB_EN for per-bank round-robin arbitration; otherwise lowest master index wins.
module tcdm_interconnect_wrapper #(
  parameter int unsigned NumMaster   = 8,
  parameter int unsigned BankFact    = 2,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned MemAddrBits = 12,
  localparam int unsigned NumBanks   = NumMaster * BankFact,
  localparam int unsigned BeWidth    = DataWidth / 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumMaster-1:0]            req_i,
  input  logic [NumMaster*DataWidth-1:0]  add_i,
  input  logic [NumMaster-1:0]            wen_i,
  input  logic [NumMaster*DataWidth-1:0]  wdata_i,
  input  logic [NumMaster*BeWidth-1:0]    be_i,
  output logic [NumMaster-1:0]            gnt_o,
  output logic [NumMaster-1:0]            vld_o,
  output logic [NumMaster*DataWidth-1:0]  rdata_o,
  output logic [NumBanks-1:0]             req_o,
  input  logic [NumBanks-1:0]             gnt_i,
  output logic [NumBanks*MemAddrBits-1:0] add_o,
  output logic [NumBanks-1:0]             wen_o,
  output logic [NumBanks*DataWidth-1:0]   wdata_o,
  output logic [NumBanks*BeWidth-1:0]     be_o,
  input  logic [NumBanks*DataWidth-1:0]   rdata_i
);

  localparam int unsigned Off      = $clog2(BeWidth);
  localparam int unsigned BankBits = $clog2(NumBanks);
  localparam int unsigned MstBits  = $clog2(NumMaster);

  logic [BankBits-1:0]    w_bank_sel   [NumMaster];
  logic [MemAddrBits-1:0] w_mem_add    [NumMaster];
  logic [DataWidth-1:0]   w_wdata      [NumMaster];
  logic [BeWidth-1:0]     w_be         [NumMaster];
  logic [DataWidth-1:0]   w_bank_rdata [NumBanks];
  logic [MstBits-1:0]     w_win        [NumBanks];
  logic [NumBanks-1:0]    w_win_vld;
  logic [NumMaster-1:0]   w_gnt;
  logic [NumMaster-1:0]   r_vld;
  logic [BankBits-1:0]    r_sel        [NumMaster];
`ifdef TCDM_RR_ARB_EN
  logic [MstBits-1:0]     r_rr_ptr     [NumBanks];
`endif

  // Address bits above the bank word address are ignored by design.
  logic w_unused_add;
  assign w_unused_add = ^add_i;

  always_comb begin
    for (int m = 0; m < NumMaster; m++) begin
      w_bank_sel[m] = add_i[m*DataWidth+Off +: BankBits];
      w_mem_add[m]  = add_i[m*DataWidth+Off+BankBits +: MemAddrBits];
      w_wdata[m]    = wdata_i[m*DataWidth +: DataWidth];
      w_be[m]       = be_i[m*BeWidth +: BeWidth];
    end
    for (int b = 0; b < NumBanks; b++) begin
      w_bank_rdata[b] = rdata_i[b*DataWidth +: DataWidth];
    end
  end

  // Scan masters starting at the bank's pointer (or 0); first requester of this bank wins.
  always_comb begin
    logic [MstBits-1:0] w_idx;
    w_idx     = '0;
    w_win     = '{default: '0};
    w_win_vld = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int i = 0; i < NumMaster; i++) begin
`ifdef TCDM_RR_ARB_EN
        w_idx = r_rr_ptr[b] + MstBits'(i);
`else
        w_idx = MstBits'(i);
`endif
        if (!w_win_vld[b] && req_i[w_idx] && (w_bank_sel[w_idx] == BankBits'(b))) begin
          w_win_vld[b] = 1'b1;
          w_win[b]     = w_idx;
        end
      end
    end
  end

  // req_o is built from requests only, never from gnt_i, to keep the bank handshake loop-free.
  always_comb begin
    req_o   = '0;
    add_o   = '0;
    wen_o   = '0;
    wdata_o = '0;
    be_o    = '0;
    w_gnt   = '0;
    for (int b = 0; b < NumBanks; b++) begin
      if (w_win_vld[b]) begin
        req_o[b]                             = 1'b1;
        add_o[b*MemAddrBits +: MemAddrBits]  = w_mem_add[w_win[b]];
        wen_o[b]                             = wen_i[w_win[b]];
        wdata_o[b*DataWidth +: DataWidth]    = w_wdata[w_win[b]];
        be_o[b*BeWidth +: BeWidth]           = w_be[w_win[b]];
        if (gnt_i[b]) begin
          w_gnt[w_win[b]] = 1'b1;
        end
      end
    end
  end

  assign gnt_o = w_gnt;
  assign vld_o = r_vld;

  always_comb begin
    rdata_o = '0;
    for (int m = 0; m < NumMaster; m++) begin
      rdata_o[m*DataWidth +: DataWidth] = w_bank_rdata[r_sel[m]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld <= '0;
      r_sel <= '{default: '0};
    end else begin
      r_vld <= w_gnt;
      for (int m = 0; m < NumMaster; m++) begin
        if (w_gnt[m]) begin
          r_sel[m] <= w_bank_sel[m];
        end
      end
    end
  end

`ifdef TCDM_RR_ARB_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '{default: '0};
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (w_win_vld[b] && gnt_i[b]) begin
          r_rr_ptr[b] <= w_win[b] + MstBits'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_interconnect_wrapper.sv
// Scoreboard bench for tcdm_interconnect_wrapper (4 masters, 8 banks, 32-bit data, 8-bit bank address).
// Follows TCDM_RR_ARB_EN for the arbitration expectations.
module tb_tcdm_interconnect_wrapper;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   wen = '0;
  logic [31:0]  add [4];
  logic [31:0]  wdata [4];
  logic [3:0]   be [4];
  logic [7:0]   gnt_b = '0;
  logic [3:0]   gnt_m, vld_m;
  logic [127:0] add_i_f, wdata_i_f, rdata_o_f;
  logic [15:0]  be_i_f;
  logic [7:0]   req_b, wen_b;
  logic [63:0]  add_o_f;
  logic [255:0] wdata_o_f, rdata_i_f;
  logic [31:0]  be_o_f;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {int due; int m; int bank; bit rd;} rsp_t;
  rsp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bank_word(int b, int c);
    return 32'hD000_0000 | (b << 16) | (c & 16'hFFFF);
  endfunction

  for (genvar m = 0; m < 4; m++) begin : g_mst
    assign add_i_f[m*32 +: 32]   = add[m];
    assign wdata_i_f[m*32 +: 32] = wdata[m];
    assign be_i_f[m*4 +: 4]      = be[m];
  end
  for (genvar b = 0; b < 8; b++) begin : g_bank
    assign rdata_i_f[b*32 +: 32] = bank_word(b, cyc);
  end

  tcdm_interconnect_wrapper #(
    .NumMaster   (4),
    .BankFact    (2),
    .DataWidth   (32),
    .MemAddrBits (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .add_i   (add_i_f),
    .wen_i   (wen),
    .wdata_i (wdata_i_f),
    .be_i    (be_i_f),
    .gnt_o   (gnt_m),
    .vld_o   (vld_m),
    .rdata_o (rdata_o_f),
    .req_o   (req_b),
    .gnt_i   (gnt_b),
    .add_o   (add_o_f),
    .wen_o   (wen_b),
    .wdata_o (wdata_o_f),
    .be_o    (be_o_f),
    .rdata_i (rdata_i_f)
  );

  // Response monitor: every negedge out of reset, vld_o must match exactly the queued grants.
  logic [3:0] mon_exp;
  rsp_t       mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_exp = '0;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_e = sbq.pop_front();
        mon_exp[mon_e.m] = 1'b1;
        if (mon_e.rd) begin
          total++;
          if (rdata_o_f[mon_e.m*32 +: 32] !== bank_word(mon_e.bank, cyc)) begin
            bad++;
            $display("FAIL rsp_rdata m%0d cyc%0d: got %h want %h", mon_e.m, cyc,
                     rdata_o_f[mon_e.m*32 +: 32], bank_word(mon_e.bank, cyc));
          end
        end
      end
      total++;
      if (vld_m !== mon_exp) begin
        bad++;
        $display("FAIL rsp_vld cyc%0d: got %b want %b", cyc, vld_m, mon_exp);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req   = '0;
    wen   = '0;
    gnt_b = 8'hFF;
    for (int m = 0; m < 4; m++) begin
      add[m]   = '0;
      wdata[m] = '0;
      be[m]    = '0;
    end
  endtask

  task automatic apply_reset();
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    sbq.delete();
    repeat (2) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++;
    if (vld_m !== 4'b0) begin bad++; $display("FAIL reset_vld: got %b want 0000", vld_m); end
    total++;
    if (req_b !== 8'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req_b); end
    next_cycle();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (req_b !== 8'b0) begin bad++; $display("FAIL post_reset_req: got %b want 0", req_b); end
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    next_cycle();
    req    = 4'b0001;
    add[0] = 32'h24;
    @(negedge clk);
    total++;
    if (req_b !== 8'b0000_0010) begin bad++; $display("FAIL sr_req: got %b want 00000010", req_b); end
    total++;
    if (add_o_f[15:8] !== 8'h01) begin bad++; $display("FAIL sr_add: got %h want 01", add_o_f[15:8]); end
    total++;
    if (wen_b[1] !== 1'b0) begin bad++; $display("FAIL sr_wen: got %b want 0", wen_b[1]); end
    total++;
    if (gnt_m !== 4'b0001) begin bad++; $display("FAIL sr_gnt: got %b want 0001", gnt_m); end
    sbq.push_back('{due: cyc + 1, m: 0, bank: 1, rd: 1'b1});
    next_cycle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_conflict();
    int exp_w;
    apply_reset();
    next_cycle();
    req = 4'b1111;
    for (int m = 0; m < 4; m++) add[m] = 32'h08;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next_cycle();
`ifdef TCDM_RR_ARB_EN
      exp_w = k % 4;
`else
      exp_w = 0;
`endif
      @(negedge clk);
      total++;
      if (gnt_m !== 4'(1 << exp_w)) begin
        bad++;
        $display("FAIL conflict_gnt k%0d: got %b want %b", k, gnt_m, 4'(1 << exp_w));
      end
      total++;
      if (req_b !== 8'b0000_0100) begin bad++; $display("FAIL conflict_req: got %b want 00000100", req_b); end
      sbq.push_back('{due: cyc + 1, m: exp_w, bank: 2, rd: 1'b1});
    end
    next_cycle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_permutation();
    apply_reset();
    next_cycle();
    req = 4'b1111;
    for (int m = 0; m < 4; m++) add[m] = 32'(8 * m);
    @(negedge clk);
    total++;
    if (gnt_m !== 4'b1111) begin bad++; $display("FAIL perm_gnt: got %b want 1111", gnt_m); end
    total++;
    if (req_b !== 8'b0101_0101) begin bad++; $display("FAIL perm_req: got %b want 01010101", req_b); end
    for (int m = 0; m < 4; m++) sbq.push_back('{due: cyc + 1, m: m, bank: 2 * m, rd: 1'b1});
    next_cycle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    apply_reset();
    next_cycle();
    req      = 4'b1000;
    wen      = 4'b1000;
    add[3]   = 32'h1C;
    wdata[3] = 32'hAABB_CCDD;
    be[3]    = 4'b0101;
    @(negedge clk);
    total++;
    if (req_b !== 8'b1000_0000) begin bad++; $display("FAIL wr_req: got %b want 10000000", req_b); end
    total++;
    if (wen_b !== 8'b1000_0000) begin bad++; $display("FAIL wr_wen: got %b want 10000000", wen_b); end
    total++;
    if (wdata_o_f[255:224] !== 32'hAABB_CCDD) begin
      bad++; $display("FAIL wr_wdata: got %h want aabbccdd", wdata_o_f[255:224]);
    end
    total++;
    if (be_o_f[31:28] !== 4'b0101) begin bad++; $display("FAIL wr_be: got %b want 0101", be_o_f[31:28]); end
    total++;
    if (gnt_m !== 4'b1000) begin bad++; $display("FAIL wr_gnt: got %b want 1000", gnt_m); end
    sbq.push_back('{due: cyc + 1, m: 3, bank: 7, rd: 1'b0});
    next_cycle();
    req = '0;
    wen = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stall();
    apply_reset();
    next_cycle();
    req    = 4'b1010;
    add[1] = 32'h14;
    add[3] = 32'h34;
    gnt_b  = 8'hDF;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      total++;
      if (gnt_m !== 4'b0000) begin bad++; $display("FAIL stall_gnt k%0d: got %b want 0000", k, gnt_m); end
      total++;
      if (add_o_f[47:40] !== 8'h00) begin
        bad++; $display("FAIL stall_winner k%0d: got %h want 00", k, add_o_f[47:40]);
      end
    end
    next_cycle();
    gnt_b = 8'hFF;
    @(negedge clk);
    total++;
    if (gnt_m !== 4'b0010) begin bad++; $display("FAIL stall_release: got %b want 0010", gnt_m); end
    sbq.push_back('{due: cyc + 1, m: 1, bank: 5, rd: 1'b1});
    next_cycle();
    @(negedge clk);
`ifdef TCDM_RR_ARB_EN
    total++;
    if (gnt_m !== 4'b1000) begin bad++; $display("FAIL stall_next: got %b want 1000", gnt_m); end
    sbq.push_back('{due: cyc + 1, m: 3, bank: 5, rd: 1'b1});
`else
    total++;
    if (gnt_m !== 4'b0010) begin bad++; $display("FAIL stall_next: got %b want 0010", gnt_m); end
    sbq.push_back('{due: cyc + 1, m: 1, bank: 5, rd: 1'b1});
`endif
    next_cycle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int          bank [4];
    logic [7:0]  word [4];
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_req;
    logic [63:0] exp_add;
    int          off;
    apply_reset();
    for (int k = 0; k < 24; k++) begin
      next_cycle();
      off     = $urandom_range(0, 7);
      req     = 4'($urandom);
      gnt_b   = 8'($urandom) | 8'h81;
      exp_gnt = '0;
      exp_req = '0;
      exp_add = '0;
      for (int m = 0; m < 4; m++) begin
        bank[m] = (2 * m + off) % 8;
        word[m] = 8'($urandom);
        add[m]  = {19'b0, word[m], 3'(bank[m]), 2'b00};
        if (req[m]) begin
          exp_req[bank[m]]          = 1'b1;
          exp_add[bank[m]*8 +: 8]   = word[m];
          exp_gnt[m]                = gnt_b[bank[m]];
        end
      end
      @(negedge clk);
      total++;
      if (gnt_m !== exp_gnt) begin bad++; $display("FAIL b2b_gnt k%0d: got %b want %b", k, gnt_m, exp_gnt); end
      total++;
      if (req_b !== exp_req) begin bad++; $display("FAIL b2b_req k%0d: got %b want %b", k, req_b, exp_req); end
      total++;
      if (add_o_f !== exp_add) begin bad++; $display("FAIL b2b_add k%0d: got %h want %h", k, add_o_f, exp_add); end
      for (int m = 0; m < 4; m++) begin
        if (exp_gnt[m]) sbq.push_back('{due: cyc + 1, m: m, bank: bank[m], rd: 1'b1});
      end
    end
    next_cycle();
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    next_cycle();
    req    = 4'b0001;
    add[0] = 32'h24;
    next_cycle();
    total++;
    if (vld_m !== 4'b0001) begin bad++; $display("FAIL mid_vld_before: got %b want 0001", vld_m); end
    rst_n = 1'b0;
    sbq.delete();
    #1;
    total++;
    if (vld_m !== 4'b0000) begin bad++; $display("FAIL mid_vld_async: got %b want 0000", vld_m); end
    next_cycle();
    rst_n = 1'b1;
    req   = '0;
    @(negedge clk);
    total++;
    if (vld_m !== 4'b0000) begin bad++; $display("FAIL mid_vld_after: got %b want 0000", vld_m); end
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_conflict();
    test_permutation();
    test_write();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
